// File: rtl/mmu_pkg.sv
// Shared definitions for the matrix-multiplication column feeder.
package mmu_pkg;

    localparam int DEPTH_W       = 32;
    localparam int COMPUTE_EXTRA = 5;
    localparam int COLLECT_EXTRA = 2;

    typedef enum logic [6:0] {
        ST_IDLE    = 7'b000_0001,
        ST_LOAD_C  = 7'b000_0010,
        ST_LOAD_A  = 7'b000_0100,
        ST_LOAD_B  = 7'b000_1000,
        ST_COMPUTE = 7'b001_0000,
        ST_COLLECT = 7'b010_0000,
        ST_DRAIN   = 7'b100_0000
    } feeder_state_e;

endpackage

// File: rtl/pe_column_feeder_if.sv
// Ready/valid word stream used for the operand input and the result output.
interface pe_column_feeder_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pe_column_feeder_result_fifo.sv
// Synchronous FIFO with a first-word-through head; head reads 0 while empty.
module result_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        count    = count_q;
        head     = empty ? '0 : mem_q[rd_ptr_q];
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pe_column_feeder.sv
// Column-edge sequencer: streams C, A, B operands into one PE column, waits out
// the compute window, then collects the column's results into an output stream.
module pe_column_feeder
    import mmu_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ARRAY_SIZE     = 16,
    parameter int PIPELINE_DEPTH = 1,
    parameter int DSP_DEPTH      = 3,
    parameter int MAX_DEPTH      = 8000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DEPTH_W-1:0]    matrix_depth,
    output logic                  busy,
    output logic                  done,
    output logic                  err_short,
    pe_column_feeder_if.slave     in_s,
    pe_column_feeder_if.master    out_m,
    output logic                  ap_start,
    output logic                  ap_ctrl,
    output logic [DEPTH_W-1:0]    ap_matrix_depth,
    output logic [DATA_WIDTH-1:0] col_data,
    input  logic                  pe_col_bc,
    input  logic [DATA_WIDTH-1:0] pe_col_data
);
    localparam int CW = $clog2(ARRAY_SIZE + 1);
    localparam logic [DEPTH_W-1:0] C_LAST        = DEPTH_W'(ARRAY_SIZE - 1);
    localparam logic [DEPTH_W-1:0] COLLECT_LAST  = DEPTH_W'(ARRAY_SIZE + COLLECT_EXTRA - 1);
    localparam logic [DEPTH_W-1:0] COMPUTE_FIXED = DEPTH_W'(PIPELINE_DEPTH + DSP_DEPTH + COMPUTE_EXTRA);

    feeder_state_e         state_q, state_d;
    logic [DEPTH_W-1:0]    cnt_q, cnt_d;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic [CW-1:0]         captured_q, captured_d;
    logic [DATA_WIDTH-1:0] col_data_q, col_data_d;
    logic                  ap_ctrl_q, ap_ctrl_d;
    logic                  ap_start_q, ap_start_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_short_q, err_short_d;
    logic                  hs;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        depth_d     = depth_q;
        captured_d  = captured_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_short_d = 1'b0;
        fifo_push   = 1'b0;
        hs          = in_ready_q && in_s.valid;
        ap_ctrl_d   = hs;
        col_data_d  = hs ? in_s.data : col_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start && matrix_depth != '0 && matrix_depth <= DEPTH_W'(MAX_DEPTH)) begin
                    depth_d    = matrix_depth;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    captured_d = '0;
                    state_d    = ST_LOAD_C;
                end
            end
            ST_LOAD_C, ST_LOAD_A, ST_LOAD_B: begin
                if (hs) begin
                    if (cnt_q == ((state_q == ST_LOAD_C) ? C_LAST : depth_q - DEPTH_W'(1))) begin
                        cnt_d   = '0;
                        state_d = (state_q == ST_LOAD_C) ? ST_LOAD_A :
                                  (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + DEPTH_W'(1);
                    end
                end
            end
            ST_COMPUTE: begin
                // Strobes seen here are B broadcasts, not results.
                if (cnt_q == depth_q + COMPUTE_FIXED - DEPTH_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_COLLECT;
                end else begin
                    cnt_d = cnt_q + DEPTH_W'(1);
                end
            end
            ST_COLLECT: begin
                if (pe_col_bc && captured_q != CW'(ARRAY_SIZE) && !fifo_full) begin
                    fifo_push  = 1'b1;
                    captured_d = captured_q + CW'(1);
                end
                if (cnt_q == COLLECT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + DEPTH_W'(1);
                end
            end
            ST_DRAIN: begin
                if (fifo_count == '0) begin
                    done_d      = 1'b1;
                    err_short_d = (captured_q != CW'(ARRAY_SIZE));
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_LOAD_C) || (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
        // Stay high one extra cycle so the last C word's ap_ctrl is covered.
        ap_start_d = (state_d == ST_LOAD_C) || (state_q == ST_LOAD_C && state_d == ST_LOAD_A);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            depth_q     <= '0;
            captured_q  <= '0;
            col_data_q  <= '0;
            ap_ctrl_q   <= 1'b0;
            ap_start_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            depth_q     <= depth_d;
            captured_q  <= captured_d;
            col_data_q  <= col_data_d;
            ap_ctrl_q   <= ap_ctrl_d;
            ap_start_q  <= ap_start_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_short_q <= err_short_d;
        end
    end

    assign fifo_pop = out_m.ready && !fifo_empty;

    result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (ARRAY_SIZE)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (pe_col_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_s.ready      = in_ready_q;
    assign out_m.valid     = !fifo_empty;
    assign out_m.data      = fifo_head;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_short       = err_short_q;
    assign ap_start        = ap_start_q;
    assign ap_ctrl         = ap_ctrl_q;
    assign ap_matrix_depth = depth_q;
    assign col_data        = col_data_q;

endmodule

// File: tb/tb_pe_column_feeder.sv
// Directed bench for pe_column_feeder with a 4-row behavioural PE column.
module tb_pe_column_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] matrix_depth;
    logic        busy, done, err_short;
    logic        ap_start, ap_ctrl;
    logic [31:0] ap_matrix_depth;
    logic [15:0] col_data;
    logic        pe_col_bc;
    logic [15:0] pe_col_data;
    logic        pe_rst_n;

    pe_column_feeder_if #(.DATA_WIDTH(16)) in_if ();
    pe_column_feeder_if #(.DATA_WIDTH(16)) out_if ();

    pe_column_feeder #(
        .DATA_WIDTH     (16),
        .ARRAY_SIZE     (4),
        .PIPELINE_DEPTH (1),
        .DSP_DEPTH      (3),
        .MAX_DEPTH      (8000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .matrix_depth    (matrix_depth),
        .busy            (busy),
        .done            (done),
        .err_short       (err_short),
        .in_s            (in_if),
        .out_m           (out_if),
        .ap_start        (ap_start),
        .ap_ctrl         (ap_ctrl),
        .ap_matrix_depth (ap_matrix_depth),
        .col_data        (col_data),
        .pe_col_bc       (pe_col_bc),
        .pe_col_data     (pe_col_data)
    );

    always #5 clk = ~clk;
    assign pe_rst_n = ~rst;

    int checks = 0;
    int errors = 0;

    // Behavioural PE column: row r returns C[r] + sum(A[j]*B[j]) after the compute window.
    logic [15:0] c_m [4];
    logic [15:0] a_m [4];
    logic [15:0] b_m [4];
    int  cidx, k, tmr;
    bit  tmr_on, start_prev;
    bit  skip_row2 = 0;
    bit  extra_strobe = 0;

    function automatic logic [15:0] pe_result(input int r);
        logic [15:0] acc;
        acc = c_m[r];
        for (int j = 0; j < 4; j++) acc = acc + a_m[j] * b_m[j];
        return acc;
    endfunction

    always @(posedge clk) begin
        pe_col_bc   <= 1'b0;
        pe_col_data <= '0;
        if (!pe_rst_n) begin
            cidx = 0; k = 0; tmr = 0; tmr_on = 0; start_prev = 0;
        end else begin
            if (ap_start && !start_prev) begin
                cidx = 0; k = 0;
            end
            start_prev = ap_start;
            if (tmr_on) begin
                if (tmr >= 13 && tmr <= 16 && !(skip_row2 && tmr == 15)) begin
                    pe_col_bc   <= 1'b1;
                    pe_col_data <= pe_result(tmr - 13);
                end
                if (extra_strobe && tmr == 17) begin
                    pe_col_bc   <= 1'b1;
                    pe_col_data <= 16'd77;
                end
                if (tmr == 20) tmr_on = 0;
                tmr++;
            end
            if (ap_ctrl) begin
                if (ap_start) begin
                    if (cidx < 4) c_m[cidx] = col_data;
                    cidx++;
                end else begin
                    if (k < 4) a_m[k] = col_data;
                    else if (k < 8) begin
                        b_m[k-4] = col_data;
                        pe_col_bc   <= 1'b1;
                        pe_col_data <= 16'hdead;
                    end
                    if (k == 7) begin tmr_on = 1; tmr = 1; end
                    k++;
                end
            end
        end
    end

    // Cycle monitor, sampled mid-cycle.
    int ctrl_cnt, start_cnt, sc_cnt, done_cnt, pop_cnt, pops_at_done;
    logic done_err;
    logic [15:0] res_q [$];

    always @(negedge clk) begin
        if (ap_ctrl) ctrl_cnt++;
        if (ap_start) start_cnt++;
        if (ap_start && ap_ctrl) sc_cnt++;
        if (done) begin
            done_cnt++;
            done_err     = err_short;
            pops_at_done = pop_cnt;
        end
        if (out_if.valid && out_if.ready) begin
            res_q.push_back(out_if.data);
            pop_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        ctrl_cnt = 0; start_cnt = 0; sc_cnt = 0; done_cnt = 0;
        pop_cnt = 0; pops_at_done = -1; done_err = 1'bx;
        res_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},     32'(busy), 0);
        check({tag, "_done"},     32'(done), 0);
        check({tag, "_err"},      32'(err_short), 0);
        check({tag, "_in_ready"}, 32'(in_if.ready), 0);
        check({tag, "_out_valid"},32'(out_if.valid), 0);
        check({tag, "_out_data"}, 32'(out_if.data), 0);
        check({tag, "_ap_start"}, 32'(ap_start), 0);
        check({tag, "_ap_ctrl"},  32'(ap_ctrl), 0);
        check({tag, "_ap_depth"}, ap_matrix_depth, 0);
        check({tag, "_col_data"}, 32'(col_data), 0);
    endtask

    task automatic start_job(input logic [31:0] d);
        matrix_depth = d;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_ap_depth", ap_matrix_depth, d);
        check("start_in_ready", 32'(in_if.ready), 1);
    endtask

    task automatic send_word(input logic [15:0] w, input bit gap);
        int n = 0;
        in_if.valid = 1'b1;
        in_if.data  = w;
        while (!in_if.ready && n < 50) begin step(); n++; end
        check("send_ready_timeout", 32'(n < 50), 1);
        step();
        in_if.valid = 1'b0;
        check("lat_col_data", 32'(col_data), 32'(w));
        check("lat_ap_ctrl", 32'(ap_ctrl), 1);
        if (gap) begin
            step();
            check("gap_ap_ctrl", 32'(ap_ctrl), 0);
            check("gap_col_hold", 32'(col_data), 32'(w));
        end
    endtask

    task automatic send_job(input bit gap);
        for (int i = 0; i < 4; i++) send_word(16'(i + 1), gap);
        for (int i = 0; i < 4; i++) send_word(16'd1, gap);
        for (int i = 0; i < 4; i++) send_word(16'd2, gap);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin step(); n++; end
        repeat (3) step();
        check("done_once", 32'(done_cnt), 1);
    endtask

    task automatic check_results(input string tag, input int n, input logic [15:0] e0,
                                 input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        check({tag, "_count"}, 32'(res_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < res_q.size()) check({tag, "_word"}, 32'(res_q[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; matrix_depth = '0;
        in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b1;
        clear_mon();

        // Reset
        repeat (3) step();
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (3) step();
        check("post_reset_busy", 32'(busy), 0);
        check("post_reset_in_ready", 32'(in_if.ready), 0);
        check("post_reset_ap_start", 32'(ap_start), 0);

        // Single job, continuous input
        clear_mon();
        start_job(4);
        send_job(1'b0);
        wait_done(200);
        check("s1_ctrl_cycles", 32'(ctrl_cnt), 12);
        check("s1_start_ctrl_cycles", 32'(sc_cnt), 4);
        check("s1_start_cycles", 32'(start_cnt), 5);
        check_results("s1", 4, 16'd9, 16'd10, 16'd11, 16'd12);
        check("s1_err_short", 32'(done_err), 0);
        check("s1_busy_after", 32'(busy), 0);

        // Gapped input, plus a fifth strobe that must be dropped
        clear_mon();
        extra_strobe = 1;
        start_job(4);
        send_job(1'b1);
        wait_done(200);
        extra_strobe = 0;
        check("s2_ctrl_cycles", 32'(ctrl_cnt), 12);
        check("s2_start_ctrl_cycles", 32'(sc_cnt), 4);
        check_results("s2", 4, 16'd9, 16'd10, 16'd11, 16'd12);
        check("s2_err_short", 32'(done_err), 0);

        // Output back-pressure
        clear_mon();
        out_if.ready = 1'b0;
        start_job(4);
        send_job(1'b0);
        repeat (38) step();
        check("s3_held_valid", 32'(out_if.valid), 1);
        check("s3_held_head", 32'(out_if.data), 9);
        check("s3_no_done", 32'(done_cnt), 0);
        check("s3_busy", 32'(busy), 1);
        out_if.ready = 1'b1;
        wait_done(200);
        check("s3_pops_at_done", 32'(pops_at_done), 4);
        check_results("s3", 4, 16'd9, 16'd10, 16'd11, 16'd12);
        check("s3_err_short", 32'(done_err), 0);

        // Illegal depths
        clear_mon();
        matrix_depth = 32'd0; start = 1'b1; step();
        check("s4_depth0_busy", 32'(busy), 0);
        matrix_depth = 32'd8001; step();
        start = 1'b0;
        check("s4_depth8001_busy", 32'(busy), 0);
        repeat (4) step();
        check("s4_in_ready", 32'(in_if.ready), 0);
        check("s4_busy", 32'(busy), 0);
        check("s4_no_done", 32'(done_cnt), 0);

        // Reset on the third A word, then a fresh job
        clear_mon();
        start_job(4);
        for (int i = 0; i < 4; i++) send_word(16'(i + 1), 1'b0);
        for (int i = 0; i < 2; i++) send_word(16'd1, 1'b0);
        in_if.valid = 1'b1; in_if.data = 16'd1; rst = 1'b1;
        step();
        in_if.valid = 1'b0;
        check_idle_outputs("s5_abort");
        rst = 1'b0;
        step();
        clear_mon();
        start_job(4);
        send_job(1'b0);
        wait_done(200);
        check_results("s5", 4, 16'd9, 16'd10, 16'd11, 16'd12);
        check("s5_err_short", 32'(done_err), 0);

        // PE row 2 silent
        clear_mon();
        skip_row2 = 1;
        start_job(4);
        send_job(1'b0);
        wait_done(200);
        skip_row2 = 0;
        check_results("s6", 3, 16'd9, 16'd10, 16'd12, 16'd0);
        check("s6_err_short", 32'(done_err), 1);
        check("s6_pops_at_done", 32'(pops_at_done), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
